// File: rtl/endgame_banner_ctrl.sv
// ----------------------------------------------------------------------------
// endgame_banner_ctrl
//
// End-of-game banner sequencer. When the game is won or lost the banner
// (WINNER or GAME OVER) appears at START_ROW, scrolls upward by STEP rows on
// every motion tick until it reaches STOP_ROW, rests there for HOLD_TICKS
// ticks, then waits for a fresh press of the restart button. The press
// produces a single-cycle game_restart pulse and the controller returns to
// idle. Game motion is frozen for the whole sequence.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   player_won   game won (level or pulse, sampled only while idle)
//   player_lost  game lost (level or pulse, sampled only while idle)
//   restart_btn  debounced restart button level
//   banner_en    banner overlay visible
//   banner_sel   00 none, 01 WINNER, 10 GAME OVER
//   banner_row   banner top row
//   banner_col   banner left column (constant BANNER_COL)
//   game_freeze  halts player/alien/missile motion
//   game_restart one-cycle restart pulse to the game logic
// ----------------------------------------------------------------------------
module endgame_banner_ctrl #(
    parameter int TICK_DIV   = 2000000,
    parameter int START_ROW  = 480,
    parameter int STOP_ROW   = 140,
    parameter int STEP       = 3,
    parameter int BANNER_COL = 195,
    parameter int HOLD_TICKS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        player_won,
    input  logic        player_lost,
    input  logic        restart_btn,
    output logic        banner_en,
    output logic [1:0]  banner_sel,
    output logic [11:0] banner_row,
    output logic [11:0] banner_col,
    output logic        game_freeze,
    output logic        game_restart
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCROLL  = 3'd1,
        HOLD    = 3'd2,
        ARMED   = 3'd3,
        RESTART = 3'd4
    } state_t;

    localparam logic [11:0] START_ROW_C  = 12'(START_ROW);
    localparam logic [11:0] STOP_ROW_C   = 12'(STOP_ROW);
    localparam logic [11:0] STEP_C       = 12'(STEP);
    localparam logic [11:0] BANNER_COL_C = 12'(BANNER_COL);
    localparam logic [31:0] TICK_LAST_C  = 32'(TICK_DIV - 1);
    localparam logic [31:0] HOLD_LAST_C  = 32'(HOLD_TICKS - 1);

    localparam logic [1:0] SEL_NONE_C = 2'b00;
    localparam logic [1:0] SEL_WIN_C  = 2'b01;
    localparam logic [1:0] SEL_LOSE_C = 2'b10;

    state_t      state_r;
    state_t      state_s;
    logic [31:0] tick_cnt_r;
    logic [31:0] tick_cnt_s;
    logic [31:0] hold_cnt_r;
    logic [31:0] hold_cnt_s;
    logic        btn_prev_r;
    logic [1:0]  sel_r;
    logic [1:0]  sel_s;
    logic [11:0] row_r;
    logic [11:0] row_s;
    logic [11:0] col_r;
    logic        en_r;
    logic        en_s;
    logic        freeze_r;
    logic        freeze_s;
    logic        restart_r;
    logic        restart_s;

    logic        tick_s;
    logic        btn_rise_s;
    logic        row_dec_ok_s;

    // Motion tick on the last count of each TICK_DIV period.
    assign tick_s = (tick_cnt_r == TICK_LAST_C);

    // Rising edge: button low at the previous edge, high now.
    assign btn_rise_s = restart_btn & ~btn_prev_r;

    // Signed 32-bit compare so row-STEP can never wrap below zero.
    assign row_dec_ok_s = ((int'({20'd0, row_r}) - STEP) > STOP_ROW);

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_s    = state_r;
        tick_cnt_s = tick_cnt_r;
        hold_cnt_s = hold_cnt_r;
        sel_s      = sel_r;
        row_s      = row_r;
        en_s       = en_r;
        freeze_s   = freeze_r;
        restart_s  = 1'b0;

        case (state_r)
            IDLE: begin
                tick_cnt_s = 32'd0;
                hold_cnt_s = 32'd0;
                row_s      = START_ROW_C;
                if (player_won) begin
                    // Win takes priority when both arrive together.
                    state_s  = SCROLL;
                    sel_s    = SEL_WIN_C;
                    en_s     = 1'b1;
                    freeze_s = 1'b1;
                end else if (player_lost) begin
                    state_s  = SCROLL;
                    sel_s    = SEL_LOSE_C;
                    en_s     = 1'b1;
                    freeze_s = 1'b1;
                end else begin
                    sel_s    = SEL_NONE_C;
                    en_s     = 1'b0;
                    freeze_s = 1'b0;
                end
            end

            SCROLL: begin
                en_s     = 1'b1;
                freeze_s = 1'b1;
                if (tick_s) begin
                    tick_cnt_s = 32'd0;
                    if (row_dec_ok_s) begin
                        row_s = row_r - STEP_C;
                    end else begin
                        row_s      = STOP_ROW_C;
                        hold_cnt_s = 32'd0;
                        state_s    = HOLD;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r + 32'd1;
                end
            end

            HOLD: begin
                en_s     = 1'b1;
                freeze_s = 1'b1;
                row_s    = STOP_ROW_C;
                if (HOLD_TICKS == 0) begin
                    tick_cnt_s = 32'd0;
                    state_s    = ARMED;
                end else if (tick_s) begin
                    tick_cnt_s = 32'd0;
                    if (hold_cnt_r == HOLD_LAST_C) begin
                        hold_cnt_s = 32'd0;
                        state_s    = ARMED;
                    end else begin
                        hold_cnt_s = hold_cnt_r + 32'd1;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r + 32'd1;
                end
            end

            ARMED: begin
                tick_cnt_s = 32'd0;
                freeze_s   = 1'b1;
                if (btn_rise_s) begin
                    state_s   = RESTART;
                    en_s      = 1'b0;
                    restart_s = 1'b1;
                end else begin
                    en_s = 1'b1;
                end
            end

            RESTART: begin
                state_s    = IDLE;
                tick_cnt_s = 32'd0;
                hold_cnt_s = 32'd0;
                sel_s      = SEL_NONE_C;
                row_s      = START_ROW_C;
                en_s       = 1'b0;
                freeze_s   = 1'b0;
            end

            default: begin
                state_s    = IDLE;
                tick_cnt_s = 32'd0;
                hold_cnt_s = 32'd0;
                sel_s      = SEL_NONE_C;
                row_s      = START_ROW_C;
                en_s       = 1'b0;
                freeze_s   = 1'b0;
            end
        endcase
    end

    // State, counters, edge detector and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            tick_cnt_r <= 32'd0;
            hold_cnt_r <= 32'd0;
            btn_prev_r <= 1'b0;
            sel_r      <= SEL_NONE_C;
            row_r      <= START_ROW_C;
            col_r      <= BANNER_COL_C;
            en_r       <= 1'b0;
            freeze_r   <= 1'b0;
            restart_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            tick_cnt_r <= tick_cnt_s;
            hold_cnt_r <= hold_cnt_s;
            btn_prev_r <= restart_btn;
            sel_r      <= sel_s;
            row_r      <= row_s;
            col_r      <= BANNER_COL_C;
            en_r       <= en_s;
            freeze_r   <= freeze_s;
            restart_r  <= restart_s;
        end
    end

    assign banner_en    = en_r;
    assign banner_sel   = sel_r;
    assign banner_row   = row_r;
    assign banner_col   = col_r;
    assign game_freeze  = freeze_r;
    assign game_restart = restart_r;

endmodule

// File: tb/tb_endgame_banner_ctrl.sv
// ----------------------------------------------------------------------------
// tb_endgame_banner_ctrl
//
// Two instances share random stimulus: instance A uses the short-tick
// configuration (480 -> 468 in steps of 5, two hold ticks) and instance B
// scrolls 10 -> 0 in steps of 7 with no hold, exercising the clamp at row 0.
// A reference model describes each game as "cycles elapsed since the banner
// appeared" and derives row, hold end and arming time arithmetically.
// Expected outputs are queued at stimulus time and popped by a monitor.
// ----------------------------------------------------------------------------
module tb_endgame_banner_ctrl;

    typedef struct packed {
        logic        en;
        logic [1:0]  sel;
        logic [11:0] row;
        logic [11:0] col;
        logic        fr;
        logic        rs;
    } exp_t;

    typedef struct {
        int td;
        int start;
        int stop;
        int step;
        int hold;
        int col;
        int k;         // tick index at which the row clamps to stop
        int armed_at;  // elapsed cycle at which restart becomes possible
        int mode;      // 0 idle, 1 banner running, 2 restart pulse
        int e;         // cycles since banner appeared
        int sel;
        bit prev;
    } model_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, player_won, player_lost, restart_btn;
    logic a_en, a_fr, a_rs, b_en, b_fr, b_rs;
    logic [1:0] a_sel, b_sel;
    logic [11:0] a_row, a_col, b_row, b_col;

    endgame_banner_ctrl #(.TICK_DIV(4), .START_ROW(480), .STOP_ROW(468),
        .STEP(5), .BANNER_COL(195), .HOLD_TICKS(2)) dut_a (
        .clk(clk), .rst(rst), .player_won(player_won),
        .player_lost(player_lost), .restart_btn(restart_btn),
        .banner_en(a_en), .banner_sel(a_sel), .banner_row(a_row),
        .banner_col(a_col), .game_freeze(a_fr), .game_restart(a_rs));

    endgame_banner_ctrl #(.TICK_DIV(4), .START_ROW(10), .STOP_ROW(0),
        .STEP(7), .BANNER_COL(33), .HOLD_TICKS(0)) dut_b (
        .clk(clk), .rst(rst), .player_won(player_won),
        .player_lost(player_lost), .restart_btn(restart_btn),
        .banner_en(b_en), .banner_sel(b_sel), .banner_row(b_row),
        .banner_col(b_col), .game_freeze(b_fr), .game_restart(b_rs));

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    model_t ma, mb;

    function automatic model_t model_init(input int td, input int start,
        input int stop, input int step, input int hold, input int col);
        model_t m;
        int n;
        m.td = td; m.start = start; m.stop = stop; m.step = step;
        m.hold = hold; m.col = col;
        n = 1;
        while (start - n * step > stop) n++;
        m.k = n;
        m.armed_at = (hold == 0) ? n * td + 1 : (n + hold) * td;
        m.mode = 0; m.e = 0; m.sel = 0; m.prev = 1'b0;
        return m;
    endfunction

    function automatic void model_step(inout model_t m, input bit r,
        input bit w, input bit l, input bit b);
        if (r) begin
            m.mode = 0; m.e = 0; m.sel = 0; m.prev = 1'b0;
        end else begin
            if (m.mode == 0) begin
                if (w || l) begin
                    m.mode = 1; m.e = 0; m.sel = w ? 1 : 2;
                end
            end else if (m.mode == 1) begin
                if (m.e >= m.armed_at && b && !m.prev) m.mode = 2;
                else m.e++;
            end else begin
                m.mode = 0; m.sel = 0;
            end
            m.prev = b;
        end
    endfunction

    function automatic exp_t model_out(input model_t m);
        exp_t x;
        int n;
        x.col = 12'(m.col);
        x.sel = 2'(m.sel);
        if (m.mode == 0) begin
            x.en = 1'b0; x.sel = 2'd0; x.row = 12'(m.start);
            x.fr = 1'b0; x.rs = 1'b0;
        end else if (m.mode == 1) begin
            n = m.e / m.td;
            x.en = 1'b1; x.fr = 1'b1; x.rs = 1'b0;
            x.row = (n >= m.k) ? 12'(m.stop) : 12'(m.start - n * m.step);
        end else begin
            x.en = 1'b0; x.fr = 1'b1; x.rs = 1'b1; x.row = 12'(m.stop);
        end
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare #1 after each edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                x = qa.pop_front();
                chk("A.banner_en", int'(a_en), int'(x.en));
                chk("A.banner_sel", int'(a_sel), int'(x.sel));
                chk("A.banner_row", int'(a_row), int'(x.row));
                chk("A.banner_col", int'(a_col), int'(x.col));
                chk("A.game_freeze", int'(a_fr), int'(x.fr));
                chk("A.game_restart", int'(a_rs), int'(x.rs));
            end
            if (qb.size() > 0) begin
                x = qb.pop_front();
                chk("B.banner_en", int'(b_en), int'(x.en));
                chk("B.banner_sel", int'(b_sel), int'(x.sel));
                chk("B.banner_row", int'(b_row), int'(x.row));
                chk("B.banner_col", int'(b_col), int'(x.col));
                chk("B.game_freeze", int'(b_fr), int'(x.fr));
                chk("B.game_restart", int'(b_rs), int'(x.rs));
            end
        end
    end

    // Stimulus: random inputs at each falling edge, expectations queued.
    initial begin
        rst = 1'b1; player_won = 1'b0; player_lost = 1'b0; restart_btn = 1'b0;
        ma = model_init(4, 480, 468, 5, 2, 195);
        mb = model_init(4, 10, 0, 7, 0, 33);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst         = (i < 3) || ($urandom_range(0, 299) == 0);
            player_won  = ($urandom_range(0, 5) == 0);
            player_lost = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 14) == 0) restart_btn = ~restart_btn;
            model_step(ma, rst, player_won, player_lost, restart_btn);
            model_step(mb, rst, player_won, player_lost, restart_btn);
            qa.push_back(model_out(ma));
            qb.push_back(model_out(mb));
        end
        @(posedge clk);
        #2;
        chk("A.queue_drained", qa.size(), 0);
        chk("B.queue_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
